// File: rtl/dii_package.sv
// dii_package: DII flit type and trace packet constants shared by packetizer and depacketizer
package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
  localparam logic [1:0] DII_TYPE_EVENT = 2'b10;
  localparam logic [3:0] TRACE_SUB_SAMPLE = 4'd0;
  localparam logic [3:0] TRACE_SUB_OVERFLOW = 4'd1;
  typedef enum logic [2:0] {S_DEST, S_SRC, S_FLAGS, S_PAYLOAD, S_DROP, S_OUT} depkt_state_t;
endpackage

// File: rtl/osd_trace_depacketization.sv
// osd_trace_depacketization: reassembles DII event packets into trace samples or overflow reports
module osd_trace_depacketization
  import dii_package::*;
#(
  parameter int WIDTH = 165
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       id,
  input  dii_flit          debug_in,
  output logic             debug_in_ready,
  output logic [WIDTH-1:0] trace_data,
  output logic             trace_overflow,
  output logic [15:0]      trace_lost,
  output logic [15:0]      trace_src,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [2:0]       err_status,
  input  logic             err_clear
);
  localparam int NW = int'($ceil(WIDTH / 16.0));
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  depkt_state_t state;
  logic [CW-1:0] cnt;
  logic fire, last, bad_flags, last_word;
  logic [2:0] set_err;
  logic [WIDTH-1:0] slot_mask, slot_data;
  assign debug_in_ready = state != S_OUT;
  assign trace_valid = state == S_OUT;
  assign trace_lost = trace_data[15:0];
  assign fire = debug_in.valid & debug_in_ready;
  assign last = debug_in.last;
  assign bad_flags = debug_in.data[15:14] != DII_TYPE_EVENT ||
                     (debug_in.data[13:10] != TRACE_SUB_SAMPLE && debug_in.data[13:10] != TRACE_SUB_OVERFLOW);
  assign last_word = cnt == (trace_overflow ? CW'(0) : CW'(NW - 1));
  // Bits shifted past WIDTH fall off, so the top slot is clipped for free
  assign slot_mask = WIDTH'(16'hffff) << {cnt, 4'b0};
  assign slot_data = WIDTH'(debug_in.data) << {cnt, 4'b0};
  always_comb begin
    set_err = 3'b000;
    if (fire) begin
      set_err[0] = (state == S_SRC && last) ||
                   (state == S_FLAGS && !bad_flags && last) ||
                   (state == S_PAYLOAD && last && !last_word);
      set_err[1] = state == S_PAYLOAD && !last && last_word;
      set_err[2] = state == S_FLAGS && bad_flags;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_DEST;
      cnt <= '0;
      err_status <= 3'b000;
      trace_data <= '0;
      trace_src <= '0;
      trace_overflow <= 1'b0;
    end else begin
      err_status <= (err_clear ? 3'b000 : err_status) | set_err;
      case (state)
        S_DEST: if (fire && !last) state <= debug_in.data[9:0] == id ? S_SRC : S_DROP;
        S_SRC: if (fire) begin
          trace_src <= debug_in.data;
          state <= last ? S_DEST : S_FLAGS;
        end
        S_FLAGS: if (fire) begin
          if (bad_flags) state <= last ? S_DEST : S_DROP;
          else begin
            cnt <= '0;
            trace_overflow <= debug_in.data[13:10] == TRACE_SUB_OVERFLOW;
            state <= last ? S_DEST : S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (fire) begin
          trace_data <= (trace_data & ~slot_mask) | slot_data;
          cnt <= cnt + 1'b1;
          if (last_word) state <= last ? S_OUT : S_DROP;
          else if (last) state <= S_DEST;
        end
        S_DROP: if (fire && last) state <= S_DEST;
        S_OUT: if (trace_ready) state <= S_DEST;
        default: state <= S_DEST;
      endcase
    end
  end
endmodule
